// File: rtl/inv_key_schedule.sv
// Reverse AES-128 key expander: loads the round-10 key and walks back to the
// round-0 key one step per accepted pull, deriving each earlier key on the fly.
module inv_key_schedule (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [127:0] lastKey,
    input  logic         next,
    output logic [127:0] roundKey,
    output logic [3:0]   round,
    output logic         keyValid,
    output logic         busy,
    output logic         done
);

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_VALID = 1'b1
    } state_e;

    // Forward AES S-box, entry 0 in the most significant byte.
    localparam logic [2047:0] SBOX_TABLE = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sbox(input logic [7:0] b);
        // 255-b equals ~b for an 8-bit index, so no subtractor is needed.
        return SBOX_TABLE[{~b, 3'b000} +: 8];
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] r);
        logic [7:0] rc;
        case (r)
            4'd1:    rc = 8'h01;
            4'd2:    rc = 8'h02;
            4'd3:    rc = 8'h04;
            4'd4:    rc = 8'h08;
            4'd5:    rc = 8'h10;
            4'd6:    rc = 8'h20;
            4'd7:    rc = 8'h40;
            4'd8:    rc = 8'h80;
            4'd9:    rc = 8'h1b;
            4'd10:   rc = 8'h36;
            default: rc = 8'h00;
        endcase
        return rc;
    endfunction

    // Undo one forward expansion step; r is the round being left.
    function automatic logic [127:0] prev_key(input logic [127:0] k, input logic [3:0] r);
        logic [31:0] w0, w1, w2, w3, n0, n1, n2, n3;
        w0 = k[127:96];
        w1 = k[95:64];
        w2 = k[63:32];
        w3 = k[31:0];
        n3 = w3 ^ w2;
        n2 = w2 ^ w1;
        n1 = w1 ^ w0;
        n0 = w0 ^ sub_word({n3[23:0], n3[31:24]}) ^ {rcon(r), 24'h000000};
        return {n0, n1, n2, n3};
    endfunction

    state_e         state_q, state_d;
    logic [127:0]   key_q, key_d;
    logic [3:0]     round_q, round_d;
    logic           done_q, done_d;
    logic [127:0]   prev_key_s;

    assign prev_key_s = prev_key(key_q, round_q);

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            key_q   <= 128'h0;
            round_q <= 4'd0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            key_q   <= key_d;
            round_q <= round_d;
            done_q  <= done_d;
        end
    end

    // Next-state logic: load on start, step back one round per accepted pull.
    always_comb begin
        state_d = state_q;
        key_d   = key_q;
        round_d = round_q;
        done_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_VALID;
                    key_d   = lastKey;
                    round_d = 4'd10;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_VALID: begin
                if (next) begin
                    if (round_q != 4'd0) begin
                        key_d   = prev_key_s;
                        round_d = round_q - 4'd1;
                    end else begin
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                    end
                end else begin
                    state_d = S_VALID;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign roundKey = key_q;
    assign round    = round_q;
    assign keyValid = (state_q == S_VALID);
    assign busy     = (state_q == S_VALID);
    assign done     = done_q;

endmodule

// File: tb/tb_inv_key_schedule.sv
// Bench for inv_key_schedule: forward AES-128 expansion model (S-box derived
// from GF(2^8) arithmetic) drives a per-cycle compare plus literal spot checks.
module tb_inv_key_schedule;

    typedef logic [127:0] sched_t [0:10];

    localparam logic [127:0] FIPS_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] FIPS_LAST = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [127:0] FIPS_R9   = 128'hac7766f319fadc2128d12941575c006e;
    localparam logic [127:0] FIPS_R1   = 128'ha0fafe1788542cb123a339392a6c7605;

    logic         clk = 1'b0;
    logic         rst, start, next;
    logic [127:0] lastKey;
    logic [127:0] roundKey;
    logic [3:0]   round;
    logic         keyValid, busy, done;

    int vectors = 0;
    int miscompares = 0;

    logic [7:0]   sb [0:255];
    sched_t       fips, pend_sched, m_sched;
    logic         m_valid = 1'b0;
    logic         m_done = 1'b0;
    logic [3:0]   m_round = 4'd0;
    logic [127:0] m_key = 128'h0;
    logic         chk_en = 1'b0;

    inv_key_schedule dut (
        .clk(clk), .rst(rst), .start(start), .lastKey(lastKey), .next(next),
        .roundKey(roundKey), .round(round), .keyValid(keyValid), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p = p ^ a;
            a = xtime(a);
            b = b >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
        return 8'((x << n) | (x >> (8 - n)));
    endfunction

    task automatic build_sbox();
        logic [7:0] inv;
        for (int a = 0; a < 256; a++) begin
            inv = 8'h00;
            for (int b = 1; b < 256; b++)
                if (gmul(8'(a), 8'(b)) == 8'h01) inv = 8'(b);
            sb[a] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    function automatic sched_t expand(input logic [127:0] k);
        logic [31:0] w [0:43];
        logic [31:0] t;
        logic [7:0]  rc;
        sched_t      s;
        for (int i = 0; i < 4; i++) w[i] = k[127 - 32*i -: 32];
        rc = 8'h01;
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sb[t[31:24]], sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]} ^ {rc, 24'h000000};
                rc = xtime(rc);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r < 11; r++) s[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
        return s;
    endfunction

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp_v);
        vectors++;
        if (act !== exp_v) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp_v);
        end
    endtask

    // Behavioural model: a loaded schedule is replayed from round 10 down to 0.
    always @(posedge clk) begin
        if (rst) begin
            m_valid <= 1'b0;
            m_round <= 4'd0;
            m_key   <= 128'h0;
            m_done  <= 1'b0;
        end else begin
            m_done <= 1'b0;
            if (!m_valid) begin
                if (start) begin
                    m_valid <= 1'b1;
                    m_round <= 4'd10;
                    m_sched <= pend_sched;
                    m_key   <= pend_sched[10];
                end
            end else if (next) begin
                if (m_round != 4'd0) begin
                    m_round <= m_round - 4'd1;
                    m_key   <= m_sched[m_round - 4'd1];
                end else begin
                    m_valid <= 1'b0;
                    m_done  <= 1'b1;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            vectors++;
            if (roundKey !== m_key || round !== m_round || keyValid !== m_valid ||
                busy !== m_valid || done !== m_done) begin
                miscompares++;
                $display("FAIL cycle t=%0t: got key=%h round=%0d valid=%b busy=%b done=%b, expected key=%h round=%0d valid=%b done=%b",
                         $time, roundKey, round, keyValid, busy, done, m_key, m_round, m_valid, m_done);
            end
        end
    end

    task automatic wait_done(input string nm);
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (m_done) break;
        end
        chk(nm, {127'h0, done}, 128'd1);
    endtask

    task automatic load_fips();
        lastKey    = FIPS_LAST;
        pend_sched = fips;
        start      = 1'b1;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        sched_t     s;
        logic [127:0] k;
        rst = 1'b1; start = 1'b0; next = 1'b0; lastKey = 128'h0;
        build_sbox();
        fips = expand(FIPS_KEY);
        pend_sched = fips;
        chk("model sbox[00]", {120'h0, sb[0]}, 128'h63);
        chk("model sbox[53]", {120'h0, sb[8'h53]}, 128'hed);
        chk("model fips r10", fips[10], FIPS_LAST);
        chk("model fips r9", fips[9], FIPS_R9);
        chk("model fips r1", fips[1], FIPS_R1);

        @(posedge clk);
        chk_en = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("reset key", roundKey, 128'h0);
        chk("reset round", {124'h0, round}, 128'd0);
        chk("reset valid", {126'h0, keyValid, busy}, 128'd0);
        rst = 1'b0;

        next = 1'b1;
        repeat (3) @(negedge clk);
        chk("idle next ignored", {127'h0, keyValid}, 128'd0);
        next = 1'b0;

        // FIPS run with next tied high
        load_fips(); next = 1'b1;
        @(negedge clk); start = 1'b0;
        chk("fips r10 key", roundKey, FIPS_LAST);
        chk("fips r10 round", {124'h0, round}, 128'd10);
        @(negedge clk);
        chk("fips r9 key", roundKey, FIPS_R9);
        repeat (8) @(negedge clk);
        chk("fips r1 key", roundKey, FIPS_R1);
        @(negedge clk);
        chk("fips r0 key", roundKey, FIPS_KEY);
        chk("fips r0 round", {124'h0, round}, 128'd0);
        @(negedge clk);
        chk("fips done cycle12", {126'h0, done, keyValid}, 128'd2);
        @(negedge clk);
        chk("fips done single", {127'h0, done}, 128'd0);
        next = 1'b0;

        // Stall at round 9, plus an ignored start mid-run
        load_fips(); next = 1'b1;
        @(negedge clk); start = 1'b0;
        @(negedge clk); next = 1'b0;
        repeat (5) begin
            @(negedge clk);
            chk("stall r9 key", roundKey, FIPS_R9);
            chk("stall r9 round", {124'h0, round}, 128'd9);
        end
        next = 1'b1;
        @(negedge clk);
        k = {$urandom, $urandom, $urandom, $urandom};
        pend_sched = expand(k);
        lastKey = pend_sched[10];
        start = 1'b1;
        @(negedge clk); start = 1'b0;
        chk("busy start ignored", roundKey, fips[7]);
        wait_done("stall run done");
        next = 1'b0;

        // Reset at round 5
        load_fips(); next = 1'b1;
        @(negedge clk); start = 1'b0;
        repeat (5) @(negedge clk);
        chk("pre-reset round5", {124'h0, round}, 128'd5);
        rst = 1'b1;
        @(negedge clk);
        chk("mid reset key", roundKey, 128'h0);
        chk("mid reset ctl", {122'h0, round, keyValid, done}, 128'd0);
        rst = 1'b0; next = 1'b0;
        load_fips();
        @(negedge clk); start = 1'b0;
        chk("restart r10 key", roundKey, FIPS_LAST);
        next = 1'b1;
        wait_done("restart done");

        // Back-to-back: start in the done cycle
        load_fips();
        @(negedge clk); start = 1'b0;
        chk("b2b valid r10", {123'h0, keyValid, round}, 128'h1a);
        wait_done("b2b done");
        next = 1'b0;
        @(negedge clk);

        // Random keys with random pull stalls
        for (int n = 0; n < 100; n++) begin
            k = {$urandom, $urandom, $urandom, $urandom};
            s = expand(k);
            pend_sched = s;
            lastKey = s[10];
            start = 1'b1;
            next = 1'($urandom_range(0, 1));
            @(negedge clk); start = 1'b0;
            for (int i = 0; i < 200; i++) begin
                next = 1'($urandom_range(0, 1));
                @(negedge clk);
                if (m_done) break;
            end
            chk("random run done", {127'h0, done}, 128'd1);
        end

        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/inv_key_schedule.md
# inv_key_schedule

- Sequential reverse AES-128 key expander for the decryption datapath.
- Loads the final (round-10) key and delivers round keys 10, 9, … 0 one at a time on a pull handshake, for the inverse-cipher AddRoundKey stage.
- Each earlier key is derived from the current one in a single cycle, so no full 11-key schedule is stored.

## Interface
Parameters: none (fixed to AES-128, Nk=4, Nr=10).

- clk  input  1  rising-edge clock; sole clock.
- rst  input  1  synchronous, active-high reset.
- start  input  1  load lastKey and begin a run; honoured only when busy=0.
- lastKey  input  128  round-10 key, word 0 in bits [127:96]; sampled on accepted start.
- next  input  1  consumer has taken roundKey; advance. Honoured only when keyValid=1.
- roundKey  output  128  current round key, same word ordering as lastKey.
- round  output  4  round index of roundKey (10 down to 0).
- keyValid  output  1  roundKey/round are valid and held stable.
- busy  output  1  run in progress (equals keyValid).
- done  output  1  one-cycle pulse after round-0 key is consumed.

## Operation
- States: IDLE, VALID.
- IDLE:
  - start=1 → VALID; roundKey←lastKey; round←10.
  - Otherwise hold roundKey/round at their last values.
- VALID:
  - next=0 → hold all outputs unchanged.
  - next=1 and round>0 → roundKey←prev(roundKey, round); round←round−1.
  - next=1 and round=0 → IDLE; done=1 for exactly one cycle; roundKey/round hold.
- prev(K, r) with K=(w0,w1,w2,w3), 32-bit words:
  - w3'=w3^w2.
  - w2'=w2^w1.
  - w1'=w1^w0.
  - w0'=w0^SubWord(RotWord(w3'))^{Rcon[r],24'h0}.
  - Result is (w0',w1',w2',w3').
- RotWord([a,b,c,d])=[b,c,d,a].
- SubWord: forward AES S-box on each byte. Four parallel lookups are implemented internally as a combinational 256-entry function.
- Rcon[r] for r=1..10: 01,02,04,08,10,20,40,80,1b,36. Index uses the round being left, not the round being produced.
- All XORs are bitwise, 128/32-bit; no carries.

## Timing
- Reset (rst=1 at a clock edge): state IDLE; roundKey=0; round=0; keyValid=0; busy=0; done=0. This applies in any state. A reset mid-run aborts with no done pulse.
- Start latency: start sampled at edge N → keyValid=1, round=10, roundKey=lastKey from edge N onward.
- Advance latency: next sampled high at edge M with keyValid=1 → new key/round visible after edge M. With next held high, a new key appears every cycle.
- Full run with next tied high: 11 valid cycles (rounds 10..0). done is high in the 12th cycle after start. keyValid and busy are low in that same cycle.
- done coincides with return to IDLE. A start asserted during the done cycle is accepted, giving back-to-back runs with no gap.
- start while busy=1: ignored; no effect on lastKey sampling.
- next while keyValid=0: ignored.
- start and next both high in IDLE: start is taken, next is ignored.
- rst has priority over start/next at the same edge.
- Outputs are registered; roundKey is never combinationally dependent on next.

## Test plan
- FIPS-197 key 2b7e151628aed2a6abf7158809cf4f3c:
  - Stimulus: start with lastKey=d014f9a8c9ee2589e13f0cc8b6630ca6, next tied high.
  - Required: round 10 shows d014f9a8…b6630ca6; round 9 = ac7766f319fadc2128d12941575c006e; round 1 = a0fafe1788542cb123a339392a6c7605; round 0 = 2b7e151628aed2a6abf7158809cf4f3c. done pulses once, cycle 12.
- Stall:
  - Stimulus: same run, next=0 for 5 cycles at round 9.
  - Required: roundKey stays ac7766f3…575c006e and round=9 throughout the stall; sequence resumes unchanged after.
- Ignored inputs:
  - Stimulus: start with a different lastKey mid-run; next pulsed while idle.
  - Required: key sequence unaffected; no state change while idle.
- Reset mid-run:
  - Stimulus: assert rst at round 5.
  - Required: next cycle all outputs 0, state IDLE, no done. A fresh start then reproduces round 10 key d014f9a8….
- Back-to-back:
  - Stimulus: start asserted in the done cycle.
  - Required: keyValid=1, round=10 on the following cycle; a second full identical sequence follows.
- Random cross-check:
  - Stimulus: 100 random 128-bit keys expanded forward by a bench reference model; the round-10 key is fed in.
  - Required: all 11 outputs match the forward schedule in reverse order.
